// File: rtl/pbus_pkg.sv
// pbus shared types and constants.
// Used by the burst transmitter and the reader side.
package pbus_pkg;

  localparam int PBUS_DW   = 32;
  localparam int PBUS_LENW = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETUP,
    STROBE
  } pbus_tx_state_t;

  function automatic int gap_w(input int setup);
    return (setup > 1) ? $clog2(setup) : 1;
  endfunction

endpackage

// File: rtl/pbus_burst_tx_if.sv
// Host and pbus signals of the burst transmitter.
// master = host/reader side, slave = transmitter.
interface pbus_burst_tx_if
  import pbus_pkg::*;
#(
  parameter int DW    = PBUS_DW,
  parameter int DEPTH = 8,
  parameter int LENW  = PBUS_LENW
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          WR_EN;
  logic [DW-1:0] WR_DATA;
  logic          FULL;
  logic          EMPTY;
  logic [LW-1:0] LEVEL;
  logic          START;
  logic [LENW-1:0] LEN;
  logic          BUSY;
  logic          DONE;
  logic [DW-1:0] DOUT;
  logic          EV;

  modport master (
    output WR_EN, WR_DATA, START, LEN,
    input  FULL, EMPTY, LEVEL,
    input  BUSY, DONE, DOUT, EV
  );

  modport slave (
    input  WR_EN, WR_DATA, START, LEN,
    output FULL, EMPTY, LEVEL,
    output BUSY, DONE, DOUT, EV
  );

endinterface

// File: rtl/pbus_sync_fifo.sv
// Single-clock word FIFO with registered level flags.
// Pushes while full are dropped; pops while empty are ignored.
module pbus_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [LW-1:0] w_level_nx;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_level_nx = r_level;
    if (w_push && !w_pop)
      w_level_nx = r_level + LW'(1);
    else if (w_pop && !w_push)
      w_level_nx = r_level - LW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wptr] <= i_data;
  end

  // pointers wrap for free since DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nx;
      r_full  <= (w_level_nx == LW'(DEPTH));
      r_empty <= (w_level_nx == '0);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_level = r_level;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/pbus_burst_tx.sv
// pbus burst transmitter: emits LEN preloaded words,
// each presented on DOUT SETUP_CYC cycles before its EV.
module pbus_burst_tx
  import pbus_pkg::*;
#(
  parameter int DW        = PBUS_DW,
  parameter int DEPTH     = 8,
  parameter int LENW      = PBUS_LENW,
  parameter int SETUP_CYC = 1
) (
  input  logic CLK,
  input  logic RST_N,
  pbus_burst_tx_if.slave bus
);

  localparam int CW = gap_w(SETUP_CYC);
  localparam int LW = $clog2(DEPTH) + 1;

  pbus_tx_state_t r_state;
  pbus_tx_state_t w_next;

  logic [LENW-1:0] r_rem;
  logic [CW-1:0]   r_gap;
  logic [DW-1:0]   r_dout;
  logic            r_ev;
  logic            r_busy;
  logic            r_done;

  logic            w_pop;
  logic            w_start;
  logic            w_zero;
  logic            w_last;
  logic [DW-1:0]   w_head;
  logic [LW-1:0]   w_level;
  logic            w_full;
  logic            w_empty;

  pbus_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_push  (bus.WR_EN),
    .i_data  (bus.WR_DATA),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_start = (r_state == IDLE) & bus.START;
  assign w_zero  = (bus.LEN == '0);
  assign w_last  = (r_state == STROBE) & (r_rem == '0);

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.START && !w_zero)
          w_next = LOAD;
      end
      LOAD: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = SETUP;
        end
      end
      SETUP: begin
        if (r_gap == '0)
          w_next = STROBE;
      end
      STROBE: begin
        w_next = (r_rem == '0) ? IDLE : LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_gap   <= '0;
      r_dout  <= '0;
      r_ev    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // EV is registered off the next state so it lines up with STROBE
      r_ev    <= (w_next == STROBE);
      r_done  <= (w_start & w_zero) | w_last;
      if (w_start && !w_zero)
        r_busy <= 1'b1;
      else if (w_last)
        r_busy <= 1'b0;
      if (w_start)
        r_rem <= bus.LEN;
      else if (w_pop)
        r_rem <= r_rem - LENW'(1);
      if (w_pop)
        r_gap <= CW'(SETUP_CYC - 1);
      else if (r_state == SETUP && r_gap != '0)
        r_gap <= r_gap - CW'(1);
      if (w_pop)
        r_dout <= w_head;
    end
  end

  assign bus.DOUT  = r_dout;
  assign bus.EV    = r_ev;
  assign bus.BUSY  = r_busy;
  assign bus.DONE  = r_done;
  assign bus.LEVEL = w_level;
  assign bus.FULL  = w_full;
  assign bus.EMPTY = w_empty;

endmodule

// File: tb/tb_pbus_burst_tx.sv
// Directed/randomized bench for pbus_burst_tx.
// Expected words come from a queue model of the FIFO.
module tb_pbus_burst_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LENW  = 16;
  localparam int SETUP = 1;
  localparam int WORD_T = SETUP + 2;

  logic CLK;
  logic RST_N;

  pbus_burst_tx_if #(
    .DW(DW), .DEPTH(DEPTH), .LENW(LENW)
  ) bus ();

  pbus_burst_tx #(
    .DW(DW), .DEPTH(DEPTH),
    .LENW(LENW), .SETUP_CYC(SETUP)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DW-1:0] ev_q[$];
  int            ev_t[$];
  int            done_cnt = 0;
  int            busy_cnt = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] last_w;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RST_N) begin
      if (bus.EV) begin
        ev_q.push_back(bus.DOUT);
        ev_t.push_back(cyc);
      end
      if (bus.DONE) done_cnt++;
      if (bus.BUSY) busy_cnt++;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = w;
    @(posedge CLK);
    #1;
    bus.WR_EN = 1'b0;
    if (model_q.size() < DEPTH)
      model_q.push_back(w);
  endtask

  task automatic start(input int len);
    bus.START = 1'b1;
    bus.LEN   = LENW'(len);
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input int d0,
                           input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      @(posedge CLK);
    end
    #1;
    chk("done_seen", 64'(done_cnt > d0), 1);
  endtask

  task automatic expect_burst(input int base,
                              input int n,
                              input bit spacing);
    chk("ev_count", 64'(ev_q.size() - base),
        64'(n));
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      w = model_q.pop_front();
      last_w = w;
      if (base + i < ev_q.size())
        chk("ev_data", 64'(ev_q[base + i]), 64'(w));
      if (spacing && i > 0 &&
          base + i < ev_t.size())
        chk("ev_gap",
            64'(ev_t[base + i] - ev_t[base + i - 1]),
            64'(WORD_T));
    end
  endtask

  initial begin
    int base, d0, b0;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = '0;
    bus.START   = 1'b0;
    bus.LEN     = '0;
    RST_N       = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_dout",  64'(bus.DOUT), 0);
    chk("rst_ev",    64'(bus.EV), 0);
    chk("rst_busy",  64'(bus.BUSY), 0);
    chk("rst_done",  64'(bus.DONE), 0);
    chk("rst_level", 64'(bus.LEVEL), 0);
    chk("rst_empty", 64'(bus.EMPTY), 1);
    chk("rst_full",  64'(bus.FULL), 0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // 1: basic four-word burst
    for (int i = 1; i <= 4; i++) push(DW'(i));
    chk("lvl4", 64'(bus.LEVEL), 4);
    base = ev_q.size();
    d0 = done_cnt;
    start(4);
    wait_done(d0, 100);
    expect_burst(base, 4, 1);
    chk("done1", 64'(done_cnt - d0), 1);
    chk("empty1", 64'(bus.EMPTY), 1);
    chk("busy1", 64'(bus.BUSY), 0);
    chk("hold1", 64'(bus.DOUT), 64'(last_w));

    // 2: zero-length request
    base = ev_q.size();
    d0 = done_cnt;
    b0 = busy_cnt;
    start(0);
    chk("len0_done", 64'(bus.DONE), 1);
    chk("len0_busy", 64'(bus.BUSY), 0);
    @(posedge CLK);
    #1;
    chk("len0_pulse", 64'(bus.DONE), 0);
    repeat (10) @(posedge CLK);
    #1;
    chk("len0_nbusy", 64'(busy_cnt - b0), 0);
    chk("len0_nev", 64'(ev_q.size() - base), 0);
    chk("len0_ndone", 64'(done_cnt - d0), 1);

    // 3: underflow stall then refill
    base = ev_q.size();
    d0 = done_cnt;
    push($urandom);
    start(3);
    repeat (20) @(posedge CLK);
    #1;
    chk("stall_ev", 64'(ev_q.size() - base), 1);
    chk("stall_busy", 64'(bus.BUSY), 1);
    chk("stall_evlo", 64'(bus.EV), 0);
    push($urandom);
    push($urandom);
    wait_done(d0, 100);
    expect_burst(base, 3, 0);
    chk("done3", 64'(done_cnt - d0), 1);

    // 4: overfill, extra words dropped
    for (int i = 0; i < 10; i++) push($urandom);
    chk("full_lvl", 64'(bus.LEVEL), 64'(DEPTH));
    chk("full_flag", 64'(bus.FULL), 1);
    chk("model_lvl", 64'(model_q.size()),
        64'(DEPTH));
    base = ev_q.size();
    d0 = done_cnt;
    start(8);
    wait_done(d0, 200);
    expect_burst(base, 8, 1);
    chk("empty4", 64'(bus.EMPTY), 1);
    chk("full4", 64'(bus.FULL), 0);

    // 5: reset in the middle of a burst
    for (int i = 0; i < 4; i++) push($urandom);
    base = ev_q.size();
    start(4);
    for (int i = 0; i < 50; i++) begin
      if (ev_q.size() >= base + 2) break;
      @(negedge CLK);
      #1;
    end
    chk("mid_ev2", 64'(ev_q.size() - base), 2);
    RST_N = 1'b0;
    #1;
    chk("mid_dout",  64'(bus.DOUT), 0);
    chk("mid_ev",    64'(bus.EV), 0);
    chk("mid_busy",  64'(bus.BUSY), 0);
    chk("mid_level", 64'(bus.LEVEL), 0);
    chk("mid_empty", 64'(bus.EMPTY), 1);
    model_q.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    push($urandom);
    push($urandom);
    base = ev_q.size();
    d0 = done_cnt;
    start(2);
    wait_done(d0, 100);
    expect_burst(base, 2, 1);

    // 6: START while busy is ignored
    for (int i = 0; i < 8; i++) push($urandom);
    base = ev_q.size();
    d0 = done_cnt;
    start(3);
    repeat (4) @(posedge CLK);
    #1;
    chk("ign_busy", 64'(bus.BUSY), 1);
    start(5);
    wait_done(d0, 100);
    repeat (30) @(posedge CLK);
    #1;
    expect_burst(base, 3, 1);
    chk("ign_done", 64'(done_cnt - d0), 1);
    chk("ign_level", 64'(bus.LEVEL),
        64'(model_q.size()));
    chk("ign_idle", 64'(bus.BUSY), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
